// File: rtl/ntt_mem_sched.sv
// rtl/ntt_mem_sched.sv - Kyber NTT RAM address/butterfly scheduler with write-back priority.
// Optional cycle counter output enabled by NTT_MEM_SCHED_STAT_EN.
module ntt_mem_sched #(
  parameter int BF_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       inv,
  output logic       busy,
  output logic       done,
  output logic [7:0] addr_1,
  output logic [7:0] addr_2,
  output logic       re,
  output logic       we_1,
  output logic       we_2,
  output logic [6:0] zeta_idx,
  output logic       bf_valid,
  output logic [2:0] layer
`ifdef NTT_MEM_SCHED_STAT_EN
  ,
  output logic [15:0] cycles
`endif
);

  localparam int WB_LAT = BF_LAT + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state_q, state_d;
  logic        inv_q, inv_d;
  logic [2:0]  layer_q, layer_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  j_q, j_d;
  logic [6:0]  k_q, k_d;
  logic        bf_valid_q, bf_valid_d;
  logic [WB_LAT-1:0] wb_v_q, wb_v_d;
  logic [7:0]  wb_a1_q [WB_LAT];
  logic [7:0]  wb_a1_d [WB_LAT];
  logic [7:0]  wb_a2_q [WB_LAT];
  logic [7:0]  wb_a2_d [WB_LAT];
`ifdef NTT_MEM_SCHED_STAT_EN
  logic [15:0] cycles_q, cycles_d;
`endif

  logic wr, rd, blk_end, layer_end, busy_s;

  always_comb begin
    state_d    = state_q;
    inv_d      = inv_q;
    layer_d    = layer_q;
    len_d      = len_q;
    j_d        = j_q;
    k_d        = k_q;
    wr         = wb_v_q[WB_LAT-1];
    rd         = (state_q == RUN) && !wr;
    busy_s     = (state_q == RUN) || (state_q == DRAIN);
    blk_end    = ((j_q + 8'd1) & (len_q - 8'd1)) == 8'd0;
    layer_end  = (j_q + len_q) == 8'hFF;
    bf_valid_d = rd;
    // A blocked read still shifts the pipeline, leaving a bubble behind the write.
    wb_v_d     = {wb_v_q[WB_LAT-2:0], rd};
    wb_a1_d[0] = j_q;
    wb_a2_d[0] = j_q + len_q;
    for (int i = 1; i < WB_LAT; i++) begin
      wb_a1_d[i] = wb_a1_q[i-1];
      wb_a2_d[i] = wb_a2_q[i-1];
    end
`ifdef NTT_MEM_SCHED_STAT_EN
    cycles_d = busy_s ? cycles_q + 16'd1 : cycles_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          inv_d   = inv;
          layer_d = 3'd0;
          j_d     = 8'd0;
          len_d   = inv ? 8'd2 : 8'd128;
          k_d     = inv ? 7'd127 : 7'd1;
`ifdef NTT_MEM_SCHED_STAT_EN
          cycles_d = 16'd0;
`endif
        end
      end
      RUN: begin
        if (rd) begin
          if (blk_end) k_d = inv_q ? k_q - 7'd1 : k_q + 7'd1;
          if (layer_end) state_d = DRAIN;
          else j_d = blk_end ? j_q + 8'd1 + len_q : j_q + 8'd1;
        end
      end
      DRAIN: begin
        // Leave once only the final write (if any) remains; next cycle is clean.
        if (wb_v_q[WB_LAT-2:0] == '0) begin
          if (layer_q == 3'd6) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            layer_d = layer_q + 3'd1;
            len_d   = inv_q ? {len_q[6:0], 1'b0} : {1'b0, len_q[7:1]};
            j_d     = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      inv_q      <= 1'b0;
      layer_q    <= 3'd0;
      len_q      <= 8'd0;
      j_q        <= 8'd0;
      k_q        <= 7'd0;
      bf_valid_q <= 1'b0;
      wb_v_q     <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        wb_a1_q[i] <= 8'd0;
        wb_a2_q[i] <= 8'd0;
      end
`ifdef NTT_MEM_SCHED_STAT_EN
      cycles_q   <= 16'd0;
`endif
    end else begin
      state_q    <= state_d;
      inv_q      <= inv_d;
      layer_q    <= layer_d;
      len_q      <= len_d;
      j_q        <= j_d;
      k_q        <= k_d;
      bf_valid_q <= bf_valid_d;
      wb_v_q     <= wb_v_d;
      for (int i = 0; i < WB_LAT; i++) begin
        wb_a1_q[i] <= wb_a1_d[i];
        wb_a2_q[i] <= wb_a2_d[i];
      end
`ifdef NTT_MEM_SCHED_STAT_EN
      cycles_q   <= cycles_d;
`endif
    end
  end

  assign busy     = busy_s;
  assign done     = (state_q == DONE);
  assign re       = rd;
  assign we_1     = wr;
  assign we_2     = wr;
  assign addr_1   = wr ? wb_a1_q[WB_LAT-1] : (rd ? j_q : 8'd0);
  assign addr_2   = wr ? wb_a2_q[WB_LAT-1] : (rd ? j_q + len_q : 8'd0);
  assign zeta_idx = rd ? k_q : 7'd0;
  assign bf_valid = bf_valid_q;
  assign layer    = layer_q;
`ifdef NTT_MEM_SCHED_STAT_EN
  assign cycles   = cycles_q;
`endif

endmodule

// File: tb/tb_ntt_mem_sched.sv
// tb/tb_ntt_mem_sched.sv - randomized self-checking bench for ntt_mem_sched.
module tb_ntt_mem_sched;
  localparam int BF_LAT = 3;
  localparam int WB_LAT = BF_LAT + 1;

  logic       clk = 1'b0;
  logic       reset, start, inv;
  logic       busy, done, re, we_1, we_2, bf_valid;
  logic [7:0] addr_1, addr_2;
  logic [6:0] zeta_idx;
  logic [2:0] layer;
`ifdef NTT_MEM_SCHED_STAT_EN
  logic [15:0] cycles;
`endif

  always #5 clk = ~clk;

  ntt_mem_sched #(.BF_LAT(BF_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .inv(inv),
    .busy(busy), .done(done), .addr_1(addr_1), .addr_2(addr_2),
    .re(re), .we_1(we_1), .we_2(we_2), .zeta_idx(zeta_idx),
    .bf_valid(bf_valid), .layer(layer)
`ifdef NTT_MEM_SCHED_STAT_EN
    , .cycles(cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {int a1; int a2; int z; int lay;} rd_t;
  typedef struct {int t; int a1; int a2; int lay;} wb_t;
  rd_t exp_q[$];

  // Reference pair order: the textbook Kyber NTT loop nest.
  task automatic build(input bit iv);
    int k, len, st;
    rd_t e;
    exp_q.delete();
    k = iv ? 127 : 1;
    for (int l = 0; l < 7; l++) begin
      len = iv ? (2 << l) : (128 >> l);
      st = 0;
      while (st < 256) begin
        for (int j = st; j < st + len; j++) begin
          e.a1 = j; e.a2 = j + len; e.z = k; e.lay = l;
          exp_q.push_back(e);
        end
        k = iv ? k - 1 : k + 1;
        st += 2 * len;
      end
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_re"}, 32'(re), 32'd0);
    chk({tag, "_we1"}, 32'(we_1), 32'd0);
    chk({tag, "_we2"}, 32'(we_2), 32'd0);
    chk({tag, "_a1"}, 32'(addr_1), 32'd0);
    chk({tag, "_a2"}, 32'(addr_2), 32'd0);
  endtask

  task automatic run(input bit iv, input int spur_at, input bit do_reset);
    wb_t wq[$];
    wb_t w;
    rd_t e;
    int c, ridx, wdone, last_w, busy_cnt;
    bit prev_rd, exp_rd, exp_wr, exp_busy, exp_done, fin;
    build(iv);
    @(negedge clk);
    start = 1'b1; inv = iv;
    @(negedge clk);
    start = 1'b0;
    c = 1; ridx = 0; wdone = 0; last_w = -10; busy_cnt = 0; prev_rd = 0; fin = 0;
    while (!fin) begin
      exp_wr   = (wq.size() > 0) && (wq[0].t == c);
      exp_rd   = !exp_wr && (ridx < 896) && ((ridx % 128 != 0) || (wdone == ridx));
      exp_busy = (wdone < 896);
      exp_done = (wdone == 896) && (c == last_w + 1);
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("re", 32'(re), 32'(exp_rd));
      chk("we_1", 32'(we_1), 32'(exp_wr));
      chk("we_2", 32'(we_2), 32'(exp_wr));
      chk("bf_valid", 32'(bf_valid), 32'(prev_rd));
      if (exp_busy) busy_cnt++;
      if (exp_wr) begin
        w = wq.pop_front();
        chk("wr_a1", 32'(addr_1), 32'(w.a1));
        chk("wr_a2", 32'(addr_2), 32'(w.a2));
        if (do_reset && w.lay == 3) begin
          reset = 1'b1;
          #1;
          idle_chk("async_rst");
          chk("async_rst_layer", 32'(layer), 32'd0);
          @(negedge clk);
          reset = 1'b0;
          return;
        end
        wdone++;
        last_w = c;
      end else if (exp_rd) begin
        e = exp_q[ridx];
        chk("rd_a1", 32'(addr_1), 32'(e.a1));
        chk("rd_a2", 32'(addr_2), 32'(e.a2));
        chk("zeta_idx", 32'(zeta_idx), 32'(e.z));
        chk("layer", 32'(layer), 32'(e.lay));
        w.t = c + WB_LAT; w.a1 = e.a1; w.a2 = e.a2; w.lay = e.lay;
        wq.push_back(w);
        ridx++;
      end else begin
        chk("idle_a1", 32'(addr_1), 32'd0);
        chk("idle_a2", 32'(addr_2), 32'd0);
      end
      if (exp_done) begin
        chk("n_reads", 32'(ridx), 32'd896);
`ifdef NTT_MEM_SCHED_STAT_EN
        chk("cycles", 32'(cycles), 32'(busy_cnt));
`endif
        fin = 1;
      end
      if (c > 3000) begin
        chk("timeout", 32'(c), 32'd3000);
        fin = 1;
      end
      prev_rd = exp_rd;
      start = (c == spur_at);
      inv = 1'($urandom);
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    idle_chk("post_done");
`ifdef NTT_MEM_SCHED_STAT_EN
    chk("cycles_hold", 32'(cycles), 32'(busy_cnt));
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; inv = 1'b0;
    repeat (3) @(negedge clk);
    idle_chk("in_rst");
    reset = 1'b0;
    @(negedge clk);
    idle_chk("after_rst");
    chk("after_rst_layer", 32'(layer), 32'd0);
    run(1'b0, int'($urandom_range(560, 740)), 1'b0);
    run(1'b1, int'($urandom_range(2, 1500)), 1'b0);
    run(1'b0, 0, 1'b1);
    run(1'b0, int'($urandom_range(2, 1700)), 1'b0);
    repeat (2) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run(1'($urandom), int'($urandom_range(2, 1700)), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
